// File: rtl/jericalla_pkg.sv
// Shared opcode encoding and pipeline stage control records for jericalla_pipe.
package jericalla_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_SLT = 3'b010,
      OP_SW  = 3'b011,
      OP_LW  = 3'b100,
      OP_AND = 3'b101,
      OP_OR  = 3'b110,
      OP_NOP = 3'b111
   } op_e;

   // Data/address widths are module parameters, so the full S1/S2 records
   // are declared in jericalla_pipe and embed these control parts.
   typedef struct packed {
      logic valid;
      op_e  op;
   } s1_ctrl_t;

   typedef struct packed {
      logic valid;
      op_e  op;
   } s2_ctrl_t;

   function automatic logic writes_reg(input op_e op);
      return op inside {OP_ADD, OP_SUB, OP_SLT, OP_AND, OP_OR, OP_LW};
   endfunction

   // Ops whose result is known combinationally while still in S1.
   function automatic logic alu_result(input op_e op);
      return op inside {OP_ADD, OP_SUB, OP_SLT, OP_AND, OP_OR};
   endfunction

endpackage

// File: rtl/jericalla_regfile.sv
// Register file: two combinational read ports, one synchronous write port, r0 hardwired to zero.
module jericalla_regfile #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RA_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [RA_W-1:0]   i_ra_addr,
   input  logic [RA_W-1:0]   i_rb_addr,
   output logic [DATA_W-1:0] o_ra_data,
   output logic [DATA_W-1:0] o_rb_data,
   input  logic              i_we,
   input  logic [RA_W-1:0]   i_wa,
   input  logic [DATA_W-1:0] i_wd
);

   logic [DATA_W-1:0] r_regs [0:2**RA_W-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 2**RA_W; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_wa != '0)) begin
         r_regs[i_wa] <= i_wd;
      end
   end

   assign o_ra_data = (i_ra_addr == '0) ? '0 : r_regs[i_ra_addr];
   assign o_rb_data = (i_rb_addr == '0) ? '0 : r_regs[i_rb_addr];

endmodule

// File: rtl/jericalla_pipe.sv
// Two-stage load/store pipeline: S1 holds resolved operands, S2 holds the result
// (ALU or memory) and writes it back to the register file on the next edge.
module jericalla_pipe
   import jericalla_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RA_W   = 5,
   parameter int unsigned MEM_AW = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3+3*RA_W-1:0]   instr,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   output logic [DATA_W-1:0]     out,
   output logic                  out_valid
);

   typedef struct packed {
      s1_ctrl_t          ctl;
      logic [RA_W-1:0]   rd;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } s1_t;

   typedef struct packed {
      s2_ctrl_t          ctl;
      logic [RA_W-1:0]   rd;
      logic [DATA_W-1:0] res;
   } s2_t;

   s1_t               r_s1;
   s2_t               r_s2;
   logic [DATA_W-1:0] r_mem [0:2**MEM_AW-1];

   op_e               w_op;
   logic [RA_W-1:0]   w_rd, w_ra, w_rb;
   logic [DATA_W-1:0] w_rf_a, w_rf_b, w_opa, w_opb, w_s1_res;
   logic [MEM_AW-1:0] w_mem_addr;
   logic              w_s1_fwd_a, w_s1_fwd_b, w_s2_fwd_a, w_s2_fwd_b;
   logic              w_stall, w_accept, w_rf_we;

   assign w_op = op_e'(instr[3+3*RA_W-1 -: 3]);
   assign w_rd = instr[3*RA_W-1 -: RA_W];
   assign w_ra = instr[2*RA_W-1 -: RA_W];
   assign w_rb = instr[RA_W-1:0];

   jericalla_regfile #(
      .DATA_W (DATA_W),
      .RA_W   (RA_W)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .i_ra_addr (w_ra),
      .i_rb_addr (w_rb),
      .o_ra_data (w_rf_a),
      .o_rb_data (w_rf_b),
      .i_we      (w_rf_we),
      .i_wa      (r_s2.rd),
      .i_wd      (r_s2.res)
   );

   always_comb begin
      w_s1_res = '0;
      case (r_s1.ctl.op)
         OP_ADD:  w_s1_res = r_s1.a + r_s1.b;
         OP_SUB:  w_s1_res = r_s1.a - r_s1.b;
         OP_SLT:  w_s1_res = ($signed(r_s1.a) < $signed(r_s1.b)) ? DATA_W'(1) : '0;
         OP_SW:   w_s1_res = r_s1.b;
         OP_AND:  w_s1_res = r_s1.a & r_s1.b;
         OP_OR:   w_s1_res = r_s1.a | r_s1.b;
         default: w_s1_res = '0;
      endcase
   end

   assign w_mem_addr = r_s1.a[MEM_AW-1:0];

   // Forwarding: S1 (only ALU ops, a load result isn't known yet) beats S2 beats the register file.
   assign w_s1_fwd_a = r_s1.ctl.valid && alu_result(r_s1.ctl.op) && (r_s1.rd != '0) && (r_s1.rd == w_ra);
   assign w_s1_fwd_b = r_s1.ctl.valid && alu_result(r_s1.ctl.op) && (r_s1.rd != '0) && (r_s1.rd == w_rb);
   assign w_s2_fwd_a = r_s2.ctl.valid && writes_reg(r_s2.ctl.op) && (r_s2.rd != '0) && (r_s2.rd == w_ra);
   assign w_s2_fwd_b = r_s2.ctl.valid && writes_reg(r_s2.ctl.op) && (r_s2.rd != '0) && (r_s2.rd == w_rb);

   assign w_opa = w_s1_fwd_a ? w_s1_res : (w_s2_fwd_a ? r_s2.res : w_rf_a);
   assign w_opb = w_s1_fwd_b ? w_s1_res : (w_s2_fwd_b ? r_s2.res : w_rf_b);

   assign w_stall = r_s1.ctl.valid && (r_s1.ctl.op == OP_LW) && (r_s1.rd != '0) &&
                    ((r_s1.rd == w_ra) || (r_s1.rd == w_rb));

   assign instr_ready = !rst && !w_stall;
   assign w_accept    = instr_valid && instr_ready;
   assign w_rf_we     = r_s2.ctl.valid && writes_reg(r_s2.ctl.op);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= '{ctl: '{valid: w_accept, op: w_op}, rd: w_rd, a: w_opa, b: w_opb};
         r_s2 <= '{ctl: '{valid: r_s1.ctl.valid, op: r_s1.ctl.op}, rd: r_s1.rd,
                   res: (r_s1.ctl.op == OP_LW) ? r_mem[w_mem_addr] : w_s1_res};
      end
   end

   // Memory has no reset; the store is suppressed on a reset edge.
   always_ff @(posedge clk) begin
      if (!rst && r_s1.ctl.valid && (r_s1.ctl.op == OP_SW)) begin
         r_mem[w_mem_addr] <= r_s1.b;
      end
   end

   assign out       = rst ? '0 : r_s2.res;
   assign out_valid = !rst && r_s2.ctl.valid && (r_s2.ctl.op != OP_NOP);

endmodule
